// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer states,
// forwarding-select codes, and the register-match helper used by stall and
// forwarding logic.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_MWAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    // A producing stage matches a consumer when it really writes a non-$0
    // register that the consumer reads (rt only counts when it is used).
    function automatic logic dst_hit(input logic [4:0] dst,
                                     input logic       wen,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
        return wen && (dst != REG_ZERO) &&
               ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage strobes / forwarding
// selects / perf counters out. The slave modport is the controller side.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);

    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_dst;
    logic [4:0]       mem_dst;
    logic [4:0]       wb_dst;
    logic             ex_regwen;
    logic             mem_regwen;
    logic             wb_regwen;
    logic             ex_memread;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             br_taken;
    logic             id_jump;
    logic             mem_busy;

    logic             pc_wen;
    logic             ifid_wen;
    logic             idex_wen;
    logic             exmem_wen;
    logic             memwb_wen;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_dst, mem_dst, wb_dst,
               ex_regwen, mem_regwen, wb_regwen, ex_memread, ex_rs, ex_rt,
               br_taken, id_jump, mem_busy,
        input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
               ifid_flush, idex_flush, fwd_a, fwd_b,
               stall_cycles, flush_events, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_dst, mem_dst, wb_dst,
               ex_regwen, mem_regwen, wb_regwen, ex_memread, ex_rs, ex_rt,
               br_taken, id_jump, mem_busy,
        output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
               ifid_flush, idex_flush, fwd_a, fwd_b,
               stall_cycles, flush_events, mem_timeout
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline.
// Optional build macro: HAZARD_FWD_EN -- adds the forwarding unit so only
// load-use hazards stall; without it every RAW dependency stalls until the
// producer has left WB.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int              TMR_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    state_e           eff_s;
    logic [1:0]       bubble_q, bubble_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       n_bubbles_s;
    logic             pc_wen_s, ifid_wen_s, idex_wen_s, exmem_wen_s, memwb_wen_s;
    logic             ifid_flush_s, idex_flush_s, flush_ev_s;
    logic [1:0]       fwd_a_s, fwd_b_s;

`ifdef HAZARD_FWD_EN
    // Only a load in EX feeding ID needs a bubble; everything else forwards.
    always_comb begin
        n_bubbles_s = 2'd0;
        if (hz.ex_memread &&
            dst_hit(hz.ex_dst, hz.ex_regwen, hz.id_rs, hz.id_rt, hz.id_uses_rt)) begin
            n_bubbles_s = 2'd1;
        end else begin
            n_bubbles_s = 2'd0;
        end
    end

    // Operand selects for the EX instruction; the younger MEM result beats WB.
    always_comb begin
        fwd_a_s = FWD_REG;
        fwd_b_s = FWD_REG;
        if (dst_hit(hz.mem_dst, hz.mem_regwen, hz.ex_rs, REG_ZERO, 1'b0)) begin
            fwd_a_s = FWD_EXMEM;
        end else if (dst_hit(hz.wb_dst, hz.wb_regwen, hz.ex_rs, REG_ZERO, 1'b0)) begin
            fwd_a_s = FWD_MEMWB;
        end else begin
            fwd_a_s = FWD_REG;
        end
        if (dst_hit(hz.mem_dst, hz.mem_regwen, hz.ex_rt, REG_ZERO, 1'b0)) begin
            fwd_b_s = FWD_EXMEM;
        end else if (dst_hit(hz.wb_dst, hz.wb_regwen, hz.ex_rt, REG_ZERO, 1'b0)) begin
            fwd_b_s = FWD_MEMWB;
        end else begin
            fwd_b_s = FWD_REG;
        end
        if (!rst_n) begin
            fwd_a_s = FWD_REG;
            fwd_b_s = FWD_REG;
        end else begin
            fwd_a_s = fwd_a_s;
            fwd_b_s = fwd_b_s;
        end
    end
`else
    // Without forwarding the ID read must wait until the producer retires;
    // the nearest producer needs the most bubbles and therefore wins.
    always_comb begin
        n_bubbles_s = 2'd0;
        if (dst_hit(hz.ex_dst, hz.ex_regwen, hz.id_rs, hz.id_rt, hz.id_uses_rt)) begin
            n_bubbles_s = 2'd3;
        end else if (dst_hit(hz.mem_dst, hz.mem_regwen, hz.id_rs, hz.id_rt, hz.id_uses_rt)) begin
            n_bubbles_s = 2'd2;
        end else if (dst_hit(hz.wb_dst, hz.wb_regwen, hz.id_rs, hz.id_rt, hz.id_uses_rt)) begin
            n_bubbles_s = 2'd1;
        end else begin
            n_bubbles_s = 2'd0;
        end
    end

    assign fwd_a_s = FWD_REG;
    assign fwd_b_s = FWD_REG;
`endif

    // Sequencer: next state, bubble/timer bookkeeping and stage strobes.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        bubble_d     = bubble_q;
        timer_d      = timer_q;
        timeout_d    = timeout_q;
        pc_wen_s     = 1'b1;
        ifid_wen_s   = 1'b1;
        idex_wen_s   = 1'b1;
        exmem_wen_s  = 1'b1;
        memwb_wen_s  = 1'b1;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        flush_ev_s   = 1'b0;
        // While waiting on memory we behave as the state we were frozen in.
        eff_s        = (state_q == ST_MWAIT) ? ret_q : state_q;

        if (!rst_n) begin
            pc_wen_s    = 1'b0;
            ifid_wen_s  = 1'b0;
            idex_wen_s  = 1'b0;
            exmem_wen_s = 1'b0;
            memwb_wen_s = 1'b0;
        end else if (hz.mem_busy) begin
            pc_wen_s    = 1'b0;
            ifid_wen_s  = 1'b0;
            idex_wen_s  = 1'b0;
            exmem_wen_s = 1'b0;
            memwb_wen_s = 1'b0;
            state_d     = ST_MWAIT;
            ret_d       = eff_s;
            if (timer_q != TMR_LIMIT) begin
                timer_d = timer_q + TMR_W'(1);
            end else begin
                timer_d = timer_q;
            end
            if (timer_d == TMR_LIMIT) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            timer_d = '0;
            state_d = eff_s;
            if (hz.br_taken) begin
                // Branch is the oldest event: squash ID and EX, drop any stall.
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
                bubble_d     = 2'd0;
                state_d      = ST_RUN;
                flush_ev_s   = 1'b1;
            end else if (eff_s == ST_STALL) begin
                pc_wen_s     = 1'b0;
                ifid_wen_s   = 1'b0;
                idex_flush_s = 1'b1;
                bubble_d     = bubble_q - 2'd1;
                state_d      = (bubble_d == 2'd0) ? ST_RUN : ST_STALL;
            end else if (hz.id_jump) begin
                ifid_flush_s = 1'b1;
                flush_ev_s   = 1'b1;
            end else if (n_bubbles_s != 2'd0) begin
                pc_wen_s     = 1'b0;
                ifid_wen_s   = 1'b0;
                idex_flush_s = 1'b1;
                bubble_d     = n_bubbles_s - 2'd1;
                state_d      = (n_bubbles_s > 2'd1) ? ST_STALL : ST_RUN;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ret_q     <= ST_RUN;
            bubble_q  <= 2'd0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            bubble_q  <= bubble_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_wen_s),
        .clear (1'b0),
        .count (hz.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_ev_s),
        .clear (1'b0),
        .count (hz.flush_events)
    );

    assign hz.pc_wen      = pc_wen_s;
    assign hz.ifid_wen    = ifid_wen_s;
    assign hz.idex_wen    = idex_wen_s;
    assign hz.exmem_wen   = exmem_wen_s;
    assign hz.memwb_wen   = memwb_wen_s;
    assign hz.ifid_flush  = ifid_flush_s;
    assign hz.idex_flush  = idex_flush_s;
    assign hz.fwd_a       = fwd_a_s;
    assign hz.fwd_b       = fwd_b_s;
    assign hz.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by random traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 8;
    localparam int MEM_TIMEOUT = 255;
    localparam int CMAX        = (1 << CNT_W) - 1;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Behavioural model: bubbles still owed, length of current busy run,
    // sticky timeout and the two counters.
    int stall_left = 0;
    int busy_run   = 0;
    bit m_timeout  = 1'b0;
    int m_stall    = 0;
    int m_flush    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hits(input logic [4:0] dst, input logic wen);
        return wen && dst != 5'd0 &&
               (dst == hz.id_rs || (hz.id_uses_rt && dst == hz.id_rt));
    endfunction

    function automatic int bubbles();
        if (FWD) return (hz.ex_memread && hits(hz.ex_dst, hz.ex_regwen)) ? 1 : 0;
        if (hits(hz.ex_dst, hz.ex_regwen))   return 3;
        if (hits(hz.mem_dst, hz.mem_regwen)) return 2;
        if (hits(hz.wb_dst, hz.wb_regwen))   return 1;
        return 0;
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] src);
        if (!FWD || !rst_n) return 2'd0;
        if (hz.mem_regwen && hz.mem_dst != 5'd0 && hz.mem_dst == src) return 2'd1;
        if (hz.wb_regwen && hz.wb_dst != 5'd0 && hz.wb_dst == src)    return 2'd2;
        return 2'd0;
    endfunction

    task automatic idle();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0;
        hz.ex_dst = 5'd0; hz.mem_dst = 5'd0; hz.wb_dst = 5'd0;
        hz.ex_regwen = 1'b0; hz.mem_regwen = 1'b0; hz.wb_regwen = 1'b0;
        hz.ex_memread = 1'b0; hz.ex_rs = 5'd0; hz.ex_rt = 5'd0;
        hz.br_taken = 1'b0; hz.id_jump = 1'b0; hz.mem_busy = 1'b0;
    endtask

    // One clock: check everything against the model with the current inputs,
    // advance the model, then return on the next falling edge.
    task automatic step();
        logic [6:0] e;
        bit         fl;
        int         n;
        #1;
        if (!rst_n) begin
            stall_left = 0; busy_run = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
        end
        chk("stall_cycles", 64'(hz.stall_cycles), 64'(m_stall));
        chk("flush_events", 64'(hz.flush_events), 64'(m_flush));
        chk("mem_timeout", 64'(hz.mem_timeout), 64'(m_timeout));
        chk("fwd_a", 64'(hz.fwd_a), 64'(fwd_exp(hz.ex_rs)));
        chk("fwd_b", 64'(hz.fwd_b), 64'(fwd_exp(hz.ex_rt)));
        e  = 7'b11111_00;
        fl = 1'b0;
        if (!rst_n) begin
            e = 7'b00000_00;
        end else if (hz.mem_busy) begin
            e = 7'b00000_00;
            busy_run++;
            if (busy_run >= MEM_TIMEOUT) m_timeout = 1'b1;
        end else begin
            busy_run = 0;
            if (hz.br_taken) begin
                e = 7'b11111_11; fl = 1'b1; stall_left = 0;
            end else if (stall_left > 0) begin
                e = 7'b00111_01; stall_left--;
            end else if (hz.id_jump) begin
                e = 7'b11111_10; fl = 1'b1;
            end else begin
                n = bubbles();
                if (n > 0) begin
                    e = 7'b00111_01; stall_left = n - 1;
                end
            end
        end
        chk("strobes", 64'({hz.pc_wen, hz.ifid_wen, hz.idex_wen, hz.exmem_wen,
                            hz.memwb_wen, hz.ifid_flush, hz.idex_flush}), 64'(e));
        if (rst_n) begin
            if (!e[6] && m_stall < CMAX) m_stall++;
            if (fl && m_flush < CMAX) m_flush++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; idle(); step();
        rst_n = 1'b1; step();
    endtask

    // Producer in EX writing $2, consumer in ID reading $2 and $4.
    task automatic load_use();
        idle();
        hz.ex_dst = 5'd2; hz.ex_regwen = 1'b1; hz.ex_memread = 1'b1;
        hz.id_rs = 5'd2; hz.id_rt = 5'd4; hz.id_uses_rt = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // Write to $0 in EX never stalls and never forwards.
        idle();
        hz.ex_dst = 5'd0; hz.ex_regwen = 1'b1; hz.ex_memread = 1'b1;
        hz.id_rs = 5'd0; hz.id_uses_rt = 1'b1;
        hz.mem_dst = 5'd0; hz.mem_regwen = 1'b1;
        step();
        chk("t3_no_stall", 64'(hz.stall_cycles), 64'd0);

        // Load-use.
        do_reset();
        load_use(); step();
        idle();
        hz.ex_rs = 5'd2; hz.ex_rt = 5'd4; hz.mem_dst = 5'd2; hz.mem_regwen = 1'b1;
        hz.id_rs = 5'd5;
        #1 chk("t2_fwd_a", 64'(hz.fwd_a), FWD ? 64'd1 : 64'd0);
        step();
        idle(); step(); step(); step();
        chk("t2_stall_cycles", 64'(hz.stall_cycles), FWD ? 64'd1 : 64'd3);

        // Reset in the middle of a stall.
        do_reset();
        load_use(); step();
        idle(); rst_n = 1'b0;
        #1 chk("t1_wen_in_reset", 64'({hz.pc_wen, hz.ifid_wen, hz.idex_wen,
                                       hz.exmem_wen, hz.memwb_wen}), 64'd0);
        step();
        rst_n = 1'b1;
        #1 chk("t1_wen_released", 64'({hz.pc_wen, hz.ifid_wen, hz.idex_wen,
                                       hz.exmem_wen, hz.memwb_wen}), 64'h1f);
        step(); step();

        // Branch taken while a stall is pending.
        do_reset();
        load_use(); step();
        idle(); hz.br_taken = 1'b1; step();
        idle(); step(); step();
        chk("t4_flush_events", 64'(hz.flush_events), 64'd1);

        // Long memory wait during a stall: timeout, saturation, resume.
        do_reset();
        load_use(); step();
        idle(); hz.mem_busy = 1'b1;
        for (int i = 0; i < 256; i++) step();
        hz.mem_busy = 1'b0;
        step(); step(); step();
        chk("t5_timeout_sticky", 64'(hz.mem_timeout), 64'd1);
        chk("t6_stall_saturated", 64'(hz.stall_cycles), 64'(CMAX));

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            hz.id_rs      = 5'($urandom_range(0, 3));
            hz.id_rt      = 5'($urandom_range(0, 3));
            hz.id_uses_rt = 1'($urandom_range(0, 1));
            hz.ex_dst     = 5'($urandom_range(0, 3));
            hz.mem_dst    = 5'($urandom_range(0, 3));
            hz.wb_dst     = 5'($urandom_range(0, 3));
            hz.ex_regwen  = 1'($urandom_range(0, 1));
            hz.mem_regwen = 1'($urandom_range(0, 1));
            hz.wb_regwen  = 1'($urandom_range(0, 1));
            hz.ex_memread = 1'($urandom_range(0, 1));
            hz.ex_rs      = 5'($urandom_range(0, 3));
            hz.ex_rt      = 5'($urandom_range(0, 3));
            hz.br_taken   = ($urandom_range(0, 7) == 0);
            hz.id_jump    = ($urandom_range(0, 7) == 0);
            hz.mem_busy   = ($urandom_range(0, 9) == 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
